mem_req_sequencer: RTL and testbench
====================================

MEM_REQ_SEQUENCER -- requirements
Module: mem_req_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, address width of requests and of the controller address.
REQ-002 Parameter DATA_WIDTH, default 8, data width of requests, responses and controller data.
REQ-003 Parameter FIFO_DEPTH, default 4, request queue entries; power of two, >=2.
REQ-004 Parameter TIMEOUT_CYCLES, default 16, wait limit in cycles; used only with MEM_REQ_TIMEOUT_EN.
REQ-005 clk  input  1  clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 req_valid  input  1  client request present.
REQ-008 req_ready  output  1  queue can accept a request.
REQ-009 req_we  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  ADDR_WIDTH  request address.
REQ-011 req_wdata  input  DATA_WIDTH  write data; don't-care for reads.
REQ-012 rsp_valid  output  1  one-cycle response pulse.
REQ-013 rsp_we  output  1  type of the completed request.
REQ-014 rsp_rdata  output  DATA_WIDTH  read data; 0 for writes.
REQ-015 rsp_err  output  1  request aborted by timeout.
REQ-016 level  output  $clog2(FIFO_DEPTH+1)  queue occupancy.
REQ-017 wr_en  output  1  write command to the memory controller.
REQ-018 rd_en  output  1  read command to the memory controller.
REQ-019 addr  output  ADDR_WIDTH  controller address.
REQ-020 wr_data  output  DATA_WIDTH  controller write data.
REQ-021 ready  input  1  controller completion pulse.
REQ-022 rd_data  input  DATA_WIDTH  controller read data; valid in the cycle ready=1.

Function
REQ-023 req_ready SHALL equal (level != FIFO_DEPTH), combinationally from registered state.
REQ-024 A push SHALL occur on a rising edge with req_valid=1 and req_ready=1, storing {req_we, req_addr, req_wdata} at the write pointer.
REQ-025 A push into a full queue SHALL NOT occur, even if a pop happens in the same cycle.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; a simultaneous push and pop SHALL leave level unchanged.
REQ-027 The FSM SHALL have the states IDLE, ISSUE and WAIT.
REQ-028 In IDLE with level>0, the FSM SHALL go to ISSUE next cycle and register addr and wr_data from the queue head (wr_data=0 for reads).
REQ-029 In ISSUE, exactly one of wr_en or rd_en (per head req_we) SHALL be 1, for exactly one cycle; the FSM then goes to WAIT.
REQ-030 In WAIT, wr_en and rd_en SHALL be 0, and addr and wr_data SHALL hold stable.
REQ-031 In WAIT with ready=1, the block SHALL on that edge pop the head and go to IDLE; next cycle rsp_valid=1, rsp_we=head type, rsp_rdata=rd_data (read) or 0 (write), rsp_err=0.
REQ-032 ready=1 in IDLE or ISSUE SHALL be ignored.
REQ-033 Only one command SHALL be outstanding; back-to-back requests SHALL be spaced by at least IDLE->ISSUE->WAIT.
REQ-034 rsp_valid SHALL be a single-cycle pulse with no backpressure.
REQ-035 Minimum latency from a push into an empty idle queue to the command pulse SHALL be 2 cycles (IDLE sees level>0, then ISSUE).

Reset
REQ-036 On rst=1 the block SHALL immediately force: the FSM to IDLE; pointers and level to 0; and wr_en, rd_en, addr, wr_data, rsp_valid, rsp_we, rsp_rdata and rsp_err to 0.
REQ-037 Reset mid-operation SHALL discard all queued and outstanding requests without a response.

Configuration
REQ-038 With MEM_REQ_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-039 With MEM_REQ_TIMEOUT_EN defined, if the counter reaches TIMEOUT_CYCLES without ready, the block SHALL pop the head and go to IDLE; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-040 Without MEM_REQ_TIMEOUT_EN, WAIT SHALL persist until ready; rsp_err SHALL remain present and tied to 0.

Verification
REQ-041 Single write: push we=1 addr=0x12 wdata=0xA5; ready two cycles after wr_en -> wr_en pulses once with addr=0x12 and wr_data=0xA5; then rsp_valid with rsp_we=1 and rsp_err=0.
REQ-042 Single read: push we=0 addr=0x34; ready with rd_data=0x5C -> rd_en pulses once; then rsp_valid with rsp_rdata=0x5C.
REQ-043 Full queue: push 5 requests with ready held 0 -> level=4, req_ready=0, fifth not accepted; then four responses in push order.
REQ-044 Simultaneous push and pop at level=2 -> level stays 2; pointer wrap is exercised over 10 requests.
REQ-045 Reset mid-WAIT: assert rst with 3 queued -> all outputs 0 and level=0 at once; no rsp_valid after release.
REQ-046 With MEM_REQ_TIMEOUT_EN and ready never asserted -> after 16 WAIT cycles, rsp_valid=1 and rsp_err=1; the next request is then issued.

Source files
------------

// File: rtl/mem_req_sequencer.sv
// mem_req_sequencer: queues client memory requests and issues them one at a
// time to a memory controller, returning a single-cycle response per request.
// Optional feature: define MEM_REQ_TIMEOUT_EN to abort a command whose
// controller completion does not arrive within TIMEOUT_CYCLES WAIT cycles.
module mem_req_sequencer #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    // client request side
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_we,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [DATA_WIDTH-1:0]            req_wdata,
    // client response side
    output logic                             rsp_valid,
    output logic                             rsp_we,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  level,
    // memory controller side
    output logic                             wr_en,
    output logic                             rd_en,
    output logic [ADDR_WIDTH-1:0]            addr,
    output logic [DATA_WIDTH-1:0]            wr_data,
    input  logic                             ready,
    input  logic [DATA_WIDTH-1:0]            rd_data
);

    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                 state, state_nxt;

    // request queue storage
    logic [FIFO_DEPTH-1:0]  q_we;
    logic [ADDR_WIDTH-1:0]  q_addr  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]  q_wdata [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;

    logic                   push, pop;
    logic                   load_cmd, done_ok, done_tmo;
    logic                   head_we;

    assign head_we   = q_we[rd_ptr];
    // full check uses only registered occupancy, so a same-cycle pop never frees a slot
    assign req_ready = (level != LW'(FIFO_DEPTH));
    assign push      = req_valid && req_ready;

    // the command strobe lasts exactly the ISSUE cycle; head type picks which one
    assign wr_en = (state == ISSUE) &&  head_we;
    assign rd_en = (state == ISSUE) && !head_we;

`ifdef MEM_REQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt;

    // count WAIT cycles; cleared while issuing so each command starts from zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  tmo_cnt <= '0;
        else if (state == ISSUE)  tmo_cnt <= '0;
        else if (state == WAIT)   tmo_cnt <= tmo_cnt + CW'(1);
    end
`else
    // timeout limit has no effect without the timeout feature
    logic [31:0] unused_tmo;
    assign unused_tmo = 32'(TIMEOUT_CYCLES);
`endif

    // queue storage writes; contents need no reset since level gates their use
    always_ff @(posedge clk) begin
        if (push) begin
            q_we[wr_ptr]    <= req_we;
            q_addr[wr_ptr]  <= req_addr;
            q_wdata[wr_ptr] <= req_wdata;
        end
    end

    // pointers wrap naturally (power-of-two depth); level tracks push/pop balance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next state and control strobes; ready outside WAIT is ignored
    always_comb begin
        state_nxt = state;
        load_cmd  = 1'b0;
        pop       = 1'b0;
        done_ok   = 1'b0;
        done_tmo  = 1'b0;
        unique case (state)
            IDLE: begin
                if (level != '0) begin
                    state_nxt = ISSUE;
                    load_cmd  = 1'b1;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (ready) begin
                    done_ok   = 1'b1;
                    pop       = 1'b1;
                    state_nxt = IDLE;
                end
`ifdef MEM_REQ_TIMEOUT_EN
                else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    done_tmo  = 1'b1;
                    pop       = 1'b1;
                    state_nxt = IDLE;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // controller address/data captured leaving IDLE and held through WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr    <= '0;
            wr_data <= '0;
        end else if (load_cmd) begin
            addr    <= q_addr[rd_ptr];
            wr_data <= head_we ? q_wdata[rd_ptr] : '0;
        end
    end

    // response registered one cycle after completion; fields zero when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_we    <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= done_ok || done_tmo;
            rsp_we    <= (done_ok || done_tmo) && head_we;
            rsp_rdata <= (done_ok && !head_we) ? rd_data : '0;
        end
    end

`ifdef MEM_REQ_TIMEOUT_EN
    // error flag marks a response produced by timeout rather than completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rsp_err <= 1'b0;
        else     rsp_err <= done_tmo;
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Bench for mem_req_sequencer: transaction-level queue model plus timing
// rules, checked every cycle, with directed literal checks and random traffic.
module tb_mem_req_sequencer;
    localparam int AW = 8, DW = 8, DEPTH = 4, TMO = 16;

    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 0, req_ready, req_we = 0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic rsp_valid, rsp_we, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [$clog2(DEPTH+1)-1:0] level;
    logic wr_en, rd_en, ready = 0;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data, rd_data = '0;

    always #5 clk = ~clk;

    mem_req_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_we(rsp_we),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .level(level), .wr_en(wr_en), .rd_en(rd_en),
        .addr(addr), .wr_data(wr_data), .ready(ready), .rd_data(rd_data));

    typedef struct {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            vis;   // first cycle the entry is counted in level
    } ent_t;

    ent_t mq[$];
    int   checks = 0, failures = 0, cyc = 0;
    bit   outst = 0;          // a command has been issued and not yet completed
    int   cmd_cyc = 0, idle_from = 0, rsp_cyc = -1;
    logic e_we, e_err;
    logic [DW-1:0] e_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Timing rule: a command fires in the first cycle after one in which the
    // sequencer was idle (nothing outstanding) and the queue already held the head.
    task automatic check_cycle();
        bit cmd, hwe;
        hwe = (mq.size() > 0) ? mq[0].we : 1'b0;
        cmd = !outst && mq.size() > 0 && mq[0].vis <= cyc - 1 && idle_from <= cyc - 1;
        if (cmd) begin outst = 1; cmd_cyc = cyc; end
        chk("level", 32'(level), 32'(mq.size()));
        chk("req_ready", req_ready, mq.size() != DEPTH);
        chk("wr_en", wr_en, cmd && hwe);
        chk("rd_en", rd_en, cmd && !hwe);
        if (outst) begin
            chk("addr", addr, mq[0].a);
            chk("wr_data", wr_data, mq[0].we ? mq[0].d : '0);
        end
        chk("rsp_valid", rsp_valid, cyc == rsp_cyc);
        if (cyc == rsp_cyc) begin
            chk("rsp_we", rsp_we, e_we);
            chk("rsp_rdata", rsp_rdata, e_rdata);
            chk("rsp_err", rsp_err, e_err);
        end
    endtask

    // Apply the effects of the coming rising edge given the inputs now driven.
    task automatic model_edge();
        bit done, tmo;
        int sz;
        done = 0; tmo = 0; sz = mq.size();
        if (outst && cyc > cmd_cyc) begin
            if (ready) done = 1;
`ifdef MEM_REQ_TIMEOUT_EN
            else if (cyc - cmd_cyc == TMO) tmo = 1;
`endif
        end
        if (done || tmo) begin
            e_we    = mq[0].we;
            e_err   = tmo;
            e_rdata = (done && !mq[0].we) ? rd_data : '0;
            rsp_cyc = cyc + 1;
            outst   = 0;
            idle_from = cyc + 1;
        end
        if (req_valid && sz < DEPTH) mq.push_back('{req_we, req_addr, req_wdata, cyc + 1});
        if (done || tmo) mq.delete(0);
    endtask

    task automatic tick(input bit v, input bit we, input logic [7:0] a, input logic [7:0] d,
                        input bit rdy, input logic [7:0] rd);
        req_valid = v; req_we = we; req_addr = a; req_wdata = d; ready = rdy; rd_data = rd;
        model_edge();
        @(negedge clk);
        cyc++;
        check_cycle();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) tick(0, 0, 8'h00, 8'h00, rdy, 8'hEE);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_level", 32'(level), 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_we", rsp_we, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        mq.delete();
        outst = 0; idle_from = 0; rsp_cyc = -1;
        req_valid = 0; ready = 0;
        @(negedge clk);
        cyc++;
        rst = 1'b0;
        check_cycle();
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("init_level", 32'(level), 0);
        chk("init_wr_en", wr_en, 0);
        chk("init_rsp_valid", rsp_valid, 0);
        rst = 1'b0;
        check_cycle();
        idle(2, 1);

        // single write, ready two cycles after wr_en
        tick(1, 1, 8'h12, 8'hA5, 0, 8'h00);
        chk("w_level", 32'(level), 1);
        tick(0, 0, 8'h00, 8'h00, 0, 8'h00);
        chk("w_wr_en", wr_en, 1);
        chk("w_addr", addr, 8'h12);
        chk("w_wr_data", wr_data, 8'hA5);
        tick(0, 0, 8'h00, 8'h00, 0, 8'h00);
        tick(0, 0, 8'h00, 8'h00, 0, 8'h00);
        tick(0, 0, 8'h00, 8'h00, 1, 8'h00);
        chk("w_rsp_valid", rsp_valid, 1);
        chk("w_rsp_we", rsp_we, 1);
        chk("w_rsp_err", rsp_err, 0);

        // single read returning 0x5C
        tick(1, 0, 8'h34, 8'hFF, 0, 8'h00);
        chk("pulse_single", rsp_valid, 0);
        tick(0, 0, 8'h00, 8'h00, 0, 8'h00);
        chk("r_rd_en", rd_en, 1);
        chk("r_addr", addr, 8'h34);
        chk("r_wr_data", wr_data, 8'h00);
        tick(0, 0, 8'h00, 8'h00, 0, 8'h00);
        tick(0, 0, 8'h00, 8'h00, 1, 8'h5C);
        chk("r_rsp_valid", rsp_valid, 1);
        chk("r_rsp_we", rsp_we, 0);
        chk("r_rsp_rdata", rsp_rdata, 8'h5C);
        idle(2, 0);

        // full queue: five pushes with ready low, fifth refused
        for (int i = 0; i < 5; i++) tick(1, i[0], 8'h40 + 8'(i), 8'h90 + 8'(i), 0, 8'h00);
        chk("full_level", 32'(level), 4);
        chk("full_req_ready", req_ready, 0);
        idle(20, 1);
        chk("drain_level", 32'(level), 0);

        // simultaneous push and pop at level 2
        tick(1, 1, 8'h51, 8'h11, 0, 8'h00);
        tick(1, 0, 8'h52, 8'h22, 0, 8'h00);
        tick(0, 0, 8'h00, 8'h00, 0, 8'h00);
        chk("pp_level_before", 32'(level), 2);
        tick(1, 1, 8'h53, 8'h33, 1, 8'h00);
        chk("pp_level_after", 32'(level), 2);
        idle(12, 1);

        // reset while waiting with three queued
        tick(1, 1, 8'h77, 8'h66, 0, 8'h00);
        tick(1, 0, 8'h78, 8'h00, 0, 8'h00);
        tick(1, 1, 8'h79, 8'h55, 0, 8'h00);
        chk("pre_rst_level", 32'(level), 3);
        do_reset();
        idle(10, 1);

`ifdef MEM_REQ_TIMEOUT_EN
        // timeout: ready never asserted, second request follows
        tick(1, 1, 8'h61, 8'h71, 0, 8'h00);
        tick(1, 0, 8'h62, 8'h00, 0, 8'h00);
        for (int i = 0; i < 17; i++) tick(0, 0, 8'h00, 8'h00, 0, 8'h00);
        chk("tmo_rsp_valid", rsp_valid, 1);
        chk("tmo_rsp_err", rsp_err, 1);
        idle(25, 0);
`endif

        // random traffic, including ready outside WAIT and pointer wrap
        for (int i = 0; i < 800; i++)
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                 $urandom_range(0, 3) == 0, 8'($urandom));
        idle(30, 1);
        chk("final_level", 32'(level), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
